fir_filter_input_sequencer: RTL and testbench

Upstream feeder for the FIR input-control/tap-pipeline stage. It collects per-channel 24-bit sample writes from the bus-side write port and assembles them into three-channel triplets, which it buffers in a small FIFO. While running, it issues one triplet per clock as input_data0/1/2 with a free-running modulo-3 phase on cnt_mod. This provides the continuous phase-rotated stream the tap pipeline shifts every cycle.

---
 rtl/fir_filter_input_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_fir_filter_input_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_input_sequencer.sv
// fir_filter_input_sequencer
// Collects per-channel sample writes into three-channel triplets, queues them
// in a small FIFO, and plays them out one triplet per clock with a rotating
// modulo-3 phase tag while running.
// Optional build macro: FIR_IN_UNDERFLOW_HOLD_EN -- when defined, an empty-FIFO
// RUN cycle repeats the last popped triplet instead of driving zeros.
module fir_filter_input_sequencer #(
    parameter int DW    = 24,
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          run,
    input  logic          flush,
    input  logic          sts_clr,
    output logic          wr_ready,
    output logic [1:0]    cnt_mod,
    output logic [DW-1:0] input_data0,
    output logic [DW-1:0] input_data1,
    output logic [DW-1:0] input_data2,
    output logic          data_valid,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    output logic          underflow,
    output logic          err_addr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [1:0]           cnt_mod_q, cnt_mod_d;
    logic [2:0][DW-1:0]   data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic [2:0][DW-1:0]   stg_q, stg_d;
    logic [2:0]           mask_q, mask_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 err_addr_q, err_addr_d;

    // Triplet storage; each word is {ch2, ch1, ch0}
    logic [3*DW-1:0]      mem_q [DEPTH];

    logic                 wr_legal;
    logic                 wr_illegal;
    logic [2:0]           wr_onehot;
    logic                 complete;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic                 uflow_set;
    logic [2:0][DW-1:0]   stg_new;
    logic [3*DW-1:0]      push_word;
    logic [3*DW-1:0]      head_word;

    // Staging view with the current write merged in, so the completing write
    // lands in the pushed triplet in the same edge.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_merge
            assign stg_new[gi] = (wr_legal && (wr_addr == 2'(gi))) ? wr_data : stg_q[gi];
            assign push_word[gi*DW +: DW] = stg_new[gi];
        end
    endgenerate

    // Write decode, FIFO status and push/pop qualification (flush blocks both)
    always_comb begin
        wr_legal   = wr_en && (wr_addr != 2'd3);
        wr_illegal = wr_en && (wr_addr == 2'd3);
        wr_onehot  = 3'b001 << wr_addr;
        complete   = wr_legal && ((mask_q | wr_onehot) == 3'b111);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == LW'(DEPTH));
        head_word  = mem_q[rd_ptr_q];
        pop        = !flush && (state_q == RUN) && run && !fifo_empty;
        push_ok    = !flush && complete && (!fifo_full || pop);
        drop       = !flush && complete && fifo_full && !pop;
    end

    // Next-state: FSM, output stream, staging, FIFO pointers and sticky status
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_mod_d    = cnt_mod_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        stg_d        = stg_q;
        mask_d       = mask_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        uflow_set    = 1'b0;

        if (flush) begin
            state_d      = IDLE;
            phase_d      = 2'd0;
            data_valid_d = 1'b0;
            mask_d       = 3'b000;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_valid_d = 1'b0;
                    phase_d      = 2'd0;
                    if (run) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // Leaving RUN: outputs hold on this edge
                        state_d = IDLE;
                    end else begin
                        cnt_mod_d = phase_q;
                        phase_d   = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                        if (!fifo_empty) begin
                            for (int c = 0; c < 3; c++) begin
                                data_d[c] = head_word[c*DW +: DW];
                            end
                            data_valid_d = 1'b1;
                        end else begin
`ifdef FIR_IN_UNDERFLOW_HOLD_EN
                            data_d = data_q;
`else
                            data_d = '0;
`endif
                            data_valid_d = 1'b0;
                            uflow_set    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (wr_legal) begin
                for (int c = 0; c < 3; c++) begin
                    if (wr_addr == 2'(c)) begin
                        stg_d[c] = wr_data;
                    end
                end
                // A completed triplet always clears the mask, pushed or dropped
                mask_d = complete ? 3'b000 : (mask_q | wr_onehot);
            end

            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end

        // Set events take precedence over a same-edge clear
        overflow_d  = drop | (overflow_q & ~sts_clr);
        underflow_d = uflow_set | (underflow_q & ~sts_clr);
        err_addr_d  = (!flush && wr_illegal) | (err_addr_q & ~sts_clr);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= 2'd0;
            cnt_mod_q    <= 2'd0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            stg_q        <= '0;
            mask_q       <= 3'b000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            err_addr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_mod_q    <= cnt_mod_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            stg_q        <= stg_d;
            mask_q       <= mask_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            err_addr_q   <= err_addr_d;
        end
    end

    // Triplet storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign wr_ready    = !fifo_full;
    assign cnt_mod     = cnt_mod_q;
    assign input_data0 = data_q[0];
    assign input_data1 = data_q[1];
    assign input_data2 = data_q[2];
    assign data_valid  = data_valid_q;
    assign fifo_level  = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_fir_filter_input_sequencer.sv
// Directed testbench for fir_filter_input_sequencer (default build).
module tb_fir_filter_input_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        run;
    logic        flush;
    logic        sts_clr;
    logic        wr_ready;
    logic [1:0]  cnt_mod;
    logic [23:0] input_data0;
    logic [23:0] input_data1;
    logic [23:0] input_data2;
    logic        data_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        underflow;
    logic        err_addr;

    int checks;
    int errors;

    fir_filter_input_sequencer #(.DW(24), .DEPTH(4), .LW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .run         (run),
        .flush       (flush),
        .sts_clr     (sts_clr),
        .wr_ready    (wr_ready),
        .cnt_mod     (cnt_mod),
        .input_data0 (input_data0),
        .input_data1 (input_data1),
        .input_data2 (input_data2),
        .data_valid  (data_valid),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_addr    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample value for triplet t, channel c: 0x(c+1)00tt
    function automatic logic [23:0] tv(input int t, input int c);
        return 24'((c + 1) * 65536 + t);
    endfunction

    function automatic logic [71:0] trip(input int t);
        return {tv(t, 2), tv(t, 1), tv(t, 0)};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load(input int t);
        wr(2'd0, tv(t, 0));
        wr(2'd1, tv(t, 1));
        wr(2'd2, tv(t, 2));
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
        run = 1'b0; flush = 1'b0; sts_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cnt_mod, input_data0, input_data1, input_data2, data_valid} !== 75'd0) begin
            errors++;
            $display("FAIL reset_outputs got cnt=%0d d0=%h d1=%h d2=%h v=%b exp all 0",
                     cnt_mod, input_data0, input_data1, input_data2, data_valid);
        end
        checks++;
        if (fifo_level !== 3'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo got level=%0d ready=%b exp level=0 ready=1", fifo_level, wr_ready);
        end
        checks++;
        if ({overflow, underflow, err_addr} !== 3'b000) begin
            errors++;
            $display("FAIL reset_sticky got %b exp 000", {overflow, underflow, err_addr});
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_basic();
        do_reset();
        wr(2'd0, 24'h000011);
        wr(2'd1, 24'h000022);
        wr(2'd2, 24'h000033);
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL basic_level got %0d exp 1", fifo_level);
        end
        run = 1'b1;
        step();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency got valid=%b exp 0", data_valid);
        end
        step();
        run = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || cnt_mod !== 2'd0 ||
            {input_data2, input_data1, input_data0} !== {24'h000033, 24'h000022, 24'h000011}) begin
            errors++;
            $display("FAIL basic_pop got v=%b cnt=%0d d=%h/%h/%h exp v=1 cnt=0 d=000011/000022/000033",
                     data_valid, cnt_mod, input_data0, input_data1, input_data2);
        end
        step();
        checks++;
        if (data_valid !== 1'b1 || input_data1 !== 24'h000022) begin
            errors++;
            $display("FAIL basic_exit_hold got v=%b d1=%h exp v=1 d1=000022", data_valid, input_data1);
        end
        step();
        checks++;
        if (data_valid !== 1'b0 || underflow !== 1'b0 || input_data1 !== 24'h000022) begin
            errors++;
            $display("FAIL basic_idle got v=%b uf=%b d1=%h exp v=0 uf=0 d1=000022",
                     data_valid, underflow, input_data1);
        end
        $display("test_basic done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int t = 0; t < 4; t++) load(t);
        checks++;
        if (fifo_level !== 3'd4 || wr_ready !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got level=%0d ready=%b ovf=%b exp 4 0 0", fifo_level, wr_ready, overflow);
        end
        load(4);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop got level=%0d ovf=%b exp 4 1", fifo_level, overflow);
        end
        run = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (data_valid !== 1'b1 || cnt_mod !== 2'(i % 3) ||
                {input_data2, input_data1, input_data0} !== trip(i) || fifo_level !== 3'(3 - i)) begin
                errors++;
                $display("FAIL ovf_pop%0d got v=%b cnt=%0d d=%h lvl=%0d exp v=1 cnt=%0d d=%h lvl=%0d",
                         i, data_valid, cnt_mod, {input_data2, input_data1, input_data0}, fifo_level,
                         i % 3, trip(i), 3 - i);
            end
        end
        step();
        run = 1'b0;
        checks++;
        if (data_valid !== 1'b0 || {input_data2, input_data1, input_data0} !== 72'd0 ||
            underflow !== 1'b1 || cnt_mod !== 2'd1) begin
            errors++;
            $display("FAIL ovf_underflow got v=%b d=%h uf=%b cnt=%0d exp v=0 d=0 uf=1 cnt=1",
                     data_valid, {input_data2, input_data1, input_data0}, underflow, cnt_mod);
        end
        step();
        sts_clr = 1'b1;
        step();
        sts_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL sts_clr got ovf=%b uf=%b exp 0 0", overflow, underflow);
        end
        $display("test_overflow done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_back_to_back();
        int exp_lvl [6];
        exp_lvl = '{4, 3, 2, 2, 1, 0};
        do_reset();
        for (int t = 0; t < 4; t++) load(t);
        wr(2'd0, tv(4, 0));
        wr(2'd1, tv(4, 1));
        run = 1'b1;
        step();
        for (int j = 0; j < 6; j++) begin
            wr_en = 1'b0;
            if (j == 0) begin wr_en = 1'b1; wr_addr = 2'd2; wr_data = tv(4, 2); end
            if (j >= 1 && j <= 3) begin wr_en = 1'b1; wr_addr = 2'(j - 1); wr_data = tv(5, j - 1); end
            step();
            wr_en = 1'b0;
            checks++;
            if (data_valid !== 1'b1 || cnt_mod !== 2'(j % 3) ||
                {input_data2, input_data1, input_data0} !== trip(j) || fifo_level !== 3'(exp_lvl[j])) begin
                errors++;
                $display("FAIL b2b_pop%0d got v=%b cnt=%0d d=%h lvl=%0d exp v=1 cnt=%0d d=%h lvl=%0d",
                         j, data_valid, cnt_mod, {input_data2, input_data1, input_data0}, fifo_level,
                         j % 3, trip(j), exp_lvl[j]);
            end
        end
        run = 1'b0;
        step();
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sticky got ovf=%b uf=%b exp 0 0", overflow, underflow);
        end
        $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_overwrite_addr();
        do_reset();
        wr(2'd1, 24'hAAAAAA);
        wr(2'd1, 24'hBBBBBB);
        wr(2'd0, 24'h123456);
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL ow_partial got level=%0d exp 0", fifo_level);
        end
        wr(2'd2, 24'h654321);
        wr(2'd3, 24'hDEAD00);
        checks++;
        if (err_addr !== 1'b1 || fifo_level !== 3'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bad_addr got err=%b lvl=%0d ovf=%b exp 1 1 0", err_addr, fifo_level, overflow);
        end
        wr(2'd0, 24'h000101);
        wr(2'd1, 24'h000202);
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL bad_addr_mask got level=%0d exp 1", fifo_level);
        end
        wr(2'd2, 24'h000303);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL bad_addr_next got level=%0d exp 2", fifo_level);
        end
        run = 1'b1;
        step();
        step();
        checks++;
        if ({input_data2, input_data1, input_data0} !== {24'h654321, 24'hBBBBBB, 24'h123456}) begin
            errors++;
            $display("FAIL ow_last_wins got %h exp %h", {input_data2, input_data1, input_data0},
                     {24'h654321, 24'hBBBBBB, 24'h123456});
        end
        step();
        run = 1'b0;
        checks++;
        if ({input_data2, input_data1, input_data0} !== {24'h000303, 24'h000202, 24'h000101}) begin
            errors++;
            $display("FAIL bad_addr_data got %h exp %h", {input_data2, input_data1, input_data0},
                     {24'h000303, 24'h000202, 24'h000101});
        end
        step();
        sts_clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 24'h1;
        step();
        sts_clr = 1'b0; wr_en = 1'b0;
        checks++;
        if (err_addr !== 1'b1) begin
            errors++;
            $display("FAIL sts_set_wins got err=%b exp 1", err_addr);
        end
        sts_clr = 1'b1;
        step();
        sts_clr = 1'b0;
        checks++;
        if (err_addr !== 1'b0) begin
            errors++;
            $display("FAIL sts_clr_err got err=%b exp 0", err_addr);
        end
        $display("test_overwrite_addr done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_flush_reset();
        do_reset();
        for (int t = 0; t < 4; t++) load(t + 16);
        run = 1'b1;
        step();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 24'hEEEEEE;
        step();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 24'hEEEEEE;
        step();
        wr_en = 1'b0;
        checks++;
        if (fifo_level !== 3'd2 || cnt_mod !== 2'd1) begin
            errors++;
            $display("FAIL flush_pre got level=%0d cnt=%0d exp 2 1", fifo_level, cnt_mod);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        run = 1'b0;
        checks++;
        if (fifo_level !== 3'd0 || data_valid !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got level=%0d v=%b ready=%b exp 0 0 1", fifo_level, data_valid, wr_ready);
        end
        step();
        checks++;
        if (data_valid !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got v=%b uf=%b exp 0 0", data_valid, underflow);
        end
        wr(2'd2, tv(9, 2));
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL flush_mask got level=%0d exp 0", fifo_level);
        end
        wr(2'd0, tv(9, 0));
        wr(2'd1, tv(9, 1));
        run = 1'b1;
        step();
        step();
        checks++;
        if (data_valid !== 1'b1 || cnt_mod !== 2'd0 || {input_data2, input_data1, input_data0} !== trip(9)) begin
            errors++;
            $display("FAIL flush_restart got v=%b cnt=%0d d=%h exp v=1 cnt=0 d=%h",
                     data_valid, cnt_mod, {input_data2, input_data1, input_data0}, trip(9));
        end
        step();
        checks++;
        if (underflow !== 1'b1 || data_valid !== 1'b0 || {input_data2, input_data1, input_data0} !== 72'd0) begin
            errors++;
            $display("FAIL flush_drain got uf=%b v=%b d=%h exp 1 0 0",
                     underflow, data_valid, {input_data2, input_data1, input_data0});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b0;
        checks++;
        if ({cnt_mod, input_data0, input_data1, input_data2, data_valid, fifo_level,
             overflow, underflow, err_addr} !== 81'd0) begin
            errors++;
            $display("FAIL midrun_reset got cnt=%0d v=%b lvl=%0d uf=%b d=%h exp all 0",
                     cnt_mod, data_valid, fifo_level, underflow, {input_data2, input_data1, input_data0});
        end
        step();
        checks++;
        if (data_valid !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got v=%b uf=%b exp 0 0", data_valid, underflow);
        end
        $display("test_flush_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_overwrite_addr();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
